sum_accum: RTL
==============

SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 4, number of accepted samples per accumulation, legal range 2..15.
REQ-002 SHALL have parameter ACC_W, default 8, accumulator/result width, legal range 6..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a new accumulation; honoured only in IDLE.
REQ-006 SHALL have port in_valid  input  1  in_data/in_cy carry a sample this cycle.
REQ-007 SHALL have port in_data  input  4  upstream 4-bit adder sum (out_data of adder).
REQ-008 SHALL have port in_cy  input  1  upstream adder carry-out (cy of adder).
REQ-009 SHALL have port out_ack  input  1  consumer accepts result; honoured only in HOLD.
REQ-010 SHALL have port busy  output  1  high in ACCUM.
REQ-011 SHALL have port out_valid  output  1  high in HOLD; result stable.
REQ-012 SHALL have port out_data  output  ACC_W  accumulated result.
REQ-013 SHALL have port ovf  output  1  sticky saturation flag for current accumulation.
REQ-014 SHALL have port sample_cnt  output  4  samples accepted in current accumulation.

Function
REQ-015 SHALL form each sample as 5-bit unsigned {in_cy, in_data}, value 0..31.
REQ-016 SHALL implement FSM states IDLE, ACCUM, HOLD; all outputs registered.
REQ-017 IDLE: start=1 SHALL clear accumulator, sample_cnt, ovf and enter ACCUM next cycle; in_valid and out_ack ignored.
REQ-018 ACCUM: each cycle with in_valid=1 SHALL add sample to accumulator and increment sample_cnt; in_valid=0 cycles (bubbles) SHALL change nothing.
REQ-019 Addition SHALL be computed at ACC_W+1 bits; if result exceeds 2^ACC_W-1, accumulator SHALL saturate at 2^ACC_W-1 and ovf SHALL set and stay set until next start or reset.
REQ-020 The cycle accepting sample number NUM_SAMPLES SHALL transition to HOLD; out_valid SHALL rise on the next clock edge (latency 1 cycle from last sample).
REQ-021 ACCUM: start SHALL be ignored; it SHALL NOT restart or clear the accumulation.
REQ-022 HOLD: out_data, ovf, sample_cnt SHALL remain stable; in_valid and start ignored.
REQ-023 HOLD: out_ack=1 SHALL return to IDLE; out_valid falls on the next edge; out_data, ovf, sample_cnt retain values in IDLE until next start.
REQ-024 HOLD with start=1 and out_ack=1 in same cycle: ack SHALL be honoured, start SHALL be dropped; a new start is required in IDLE.
REQ-025 sample_cnt SHALL never exceed NUM_SAMPLES; no wrap-around.

Reset
REQ-026 rst=1 SHALL immediately (without clock) force IDLE, busy=0, out_valid=0, out_data=0, ovf=0, sample_cnt=0.
REQ-027 rst asserted mid-ACCUM or mid-HOLD SHALL discard the partial/held result; first cycle after rst deasserts SHALL be IDLE.

Verification
REQ-028 Reset: assert rst with no clock edge -> all outputs 0, state IDLE.
REQ-029 Basic (NUM_SAMPLES=4): start; samples {0,0001},{0,0010},{0,0100},{1,0000} back-to-back -> out_valid high 1 cycle after 4th sample, out_data=0x17, ovf=0, sample_cnt=4; out_ack -> out_valid=0 next cycle.
REQ-030 Bubbles: same four samples with in_valid low for 2 cycles between each -> identical out_data=0x17, sample_cnt=4; busy high throughout.
REQ-031 Saturation (NUM_SAMPLES=10, ACC_W=8): ten samples {1,1111} -> ovf sets on 9th sample (279>255), out_data=0xFF, ovf=1, sample_cnt=10.
REQ-032 Reset mid-op: start, 2 samples, assert rst -> outputs 0 immediately; after release, start with 4 samples {0,0001} -> out_data=0x04.
REQ-033 Ignored controls: start pulsed during ACCUM -> no effect on count/sum; in HOLD start+out_ack together -> IDLE, busy stays 0 until a fresh start.

Source files
------------

// File: rtl/sum_accum.sv
// rtl/sum_accum.sv - saturating accumulator of NUM_SAMPLES 5-bit adder results
module sum_accum #(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  input  logic             in_cy,
  input  logic             out_ack,
  output logic             busy,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             ovf,
  output logic [3:0]       sample_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [3:0]       LAST_CNT = 4'(NUM_SAMPLES - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [3:0]       r_cnt;

  logic [ACC_W:0]   w_sample;
  logic [ACC_W:0]   w_sum;
  logic             w_sat;
  logic [ACC_W-1:0] w_acc_next;

  // The sample is the upstream carry on top of its 4-bit sum; the add is one bit
  // wider than the accumulator so that the top bit flags saturation directly.
  assign w_sample   = {{(ACC_W-4){1'b0}}, in_cy, in_data};
  assign w_sum      = {1'b0, r_acc} + w_sample;
  assign w_sat      = w_sum[ACC_W];
  assign w_acc_next = w_sat ? ACC_MAX : w_sum[ACC_W-1:0];

  // Control FSM; every output is its own register, updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_sat;
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == LAST_CNT) begin
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // A start arriving together with the ack is dropped on purpose.
          if (out_ack) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign out_valid  = r_out_valid;
  assign out_data   = r_acc;
  assign ovf        = r_ovf;
  assign sample_cnt = r_cnt;

endmodule
